// File: rtl/hpdcache_pkg.sv
// hpdcache_pkg: shared sizing constants and helpers for HPDcache buffering blocks
package hpdcache_pkg;
  localparam int unsigned HPDCACHE_MSHR_SETS = 4;
  localparam int unsigned HPDCACHE_MSHR_WAYS = 2;
  localparam int unsigned HPDCACHE_REFILL_FIFO_MARGIN = 2;
  localparam int unsigned HPDCACHE_REFILL_FIFO_DEPTH =
    HPDCACHE_MSHR_SETS * HPDCACHE_MSHR_WAYS + HPDCACHE_REFILL_FIFO_MARGIN;
  function automatic int unsigned hpdcache_fifo_cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/hpdcache_cfg_fifo_if.sv
// hpdcache_cfg_fifo_if: push/pop handshake and status bundle of the configurable FIFO
interface hpdcache_cfg_fifo_if
  import hpdcache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CW = hpdcache_fifo_cnt_width(DEPTH);
  logic flush_i;
  logic w_i;
  logic wok_o;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic r_i;
  logic rok_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic [CW-1:0] count_o;
  logic afull_o;
  logic err_o;
  modport master (
    output flush_i, w_i, wdata_i, r_i,
    input  wok_o, rok_o, rdata_o, count_o, afull_o, err_o
  );
  modport slave (
    input  flush_i, w_i, wdata_i, r_i,
    output wok_o, rok_o, rdata_o, count_o, afull_o, err_o
  );
endinterface

// File: rtl/hpdcache_fifo_regbank.sv
// hpdcache_fifo_regbank: flop storage, one write port, asynchronous read at raddr
module hpdcache_fifo_regbank #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PW = 1
) (
  input  logic clk_i,
  input  logic we,
  input  logic [PW-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PW-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk_i)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/hpdcache_cfg_fifo.sv
// hpdcache_cfg_fifo: parametrised FIFO with optional feedthrough, flush, almost-full,
// occupancy and a sticky protocol-error flag.
module hpdcache_cfg_fifo
  import hpdcache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  parameter bit FEEDTHROUGH = 1'b0,
  parameter int unsigned AFULL_THRESH = DEPTH
) (
  input logic clk_i,
  input logic rst_i,
  hpdcache_cfg_fifo_if.slave fifo
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = hpdcache_fifo_cnt_width(DEPTH);
  logic [PW-1:0] rptr, wptr;
  logic [CW-1:0] count;
  logic err;
  logic empty, full, push, pop, bypass, wr, rd, err_set;
  logic [DATA_WIDTH-1:0] mem_rdata;
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign empty = (count == '0);
  assign full = (count == CW'(DEPTH));
  assign fifo.wok_o = !full && !fifo.flush_i;
  assign fifo.rok_o = (!empty || (FEEDTHROUGH && fifo.w_i)) && !fifo.flush_i;
  assign fifo.rdata_o = (FEEDTHROUGH && empty) ? fifo.wdata_i : mem_rdata;
  assign fifo.count_o = count;
  assign fifo.afull_o = (count >= CW'(AFULL_THRESH));
  assign fifo.err_o = err;
  assign push = fifo.w_i && fifo.wok_o;
  assign pop = fifo.r_i && fifo.rok_o;
  // an empty feedthrough FIFO hands the pushed word straight to the consumer
  assign bypass = FEEDTHROUGH && empty && push && pop;
  assign wr = push && !bypass;
  assign rd = pop && !bypass;
  assign err_set = !fifo.flush_i && ((fifo.w_i && !fifo.wok_o) || (fifo.r_i && !fifo.rok_o));
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
      err <= 1'b0;
    end else if (fifo.flush_i) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
      err <= 1'b0;
    end else begin
      if (wr) wptr <= ptr_inc(wptr);
      if (rd) rptr <= ptr_inc(rptr);
      count <= count + CW'(wr) - CW'(rd);
      err <= err | err_set;
    end
  hpdcache_fifo_regbank #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH(DEPTH),
    .PW(PW)
  ) u_regbank (
    .clk_i(clk_i),
    .we(wr),
    .waddr(wptr),
    .wdata(fifo.wdata_i),
    .raddr(rptr),
    .rdata(mem_rdata)
  );
endmodule

// File: doc/hpdcache_cfg_fifo.md
Name: hpdcache_cfg_fifo

Overview:
- Generic, fully parametrised FIFO for HPDcache internal buffering: refill-to-core responses, write-buffer send path and MSHR-sized queues.
- Adds per-instance depth and width, an optional same-cycle feedthrough mode, a synchronous flush, an almost-full threshold, occupancy output and a sticky protocol-error flag.
- Sits between producer and consumer stages using valid/ready-style handshakes.

Parameters:
- DATA_WIDTH, 64, bits per entry; must be ≥1.
- DEPTH, 2, number of storage entries; must be ≥1; any value, not limited to powers of two.
- FEEDTHROUGH, 1'b0, when 1 a push into an empty FIFO is visible at the output in the same cycle.
- AFULL_THRESH, DEPTH, `afull_o` asserts when occupancy ≥ this value; must be in 1..DEPTH.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous clear of all contents.
- w_i  in  1  push request.
- wok_o  out  1  push accepted when w_i && wok_o.
- wdata_i  in  DATA_WIDTH  push data.
- r_i  in  1  pop request.
- rok_o  out  1  output valid; pop happens when r_i && rok_o.
- rdata_o  out  DATA_WIDTH  head data.
- count_o  out  $clog2(DEPTH+1)  current occupancy.
- afull_o  out  1  occupancy ≥ AFULL_THRESH.
- err_o  out  1  sticky error: push while !wok_o, or pop while !rok_o.

Behaviour:
- State: storage array[DEPTH], rptr/wptr of width max(1,$clog2(DEPTH)), count, err.
- Reset (async, rst_i=1): rptr=wptr=0, count=0, err=0. Resulting outputs:
  - FEEDTHROUGH=0: wok_o=1, rok_o=0, count_o=0, afull_o=0, err_o=0.
  - FEEDTHROUGH=1: rok_o follows w_i.
  - Storage contents are not reset.
- Pointer wrap: a pointer advances to 0 after DEPTH-1. Explicit compare is required, since DEPTH may be a non-power of two.
- wok_o = !full && !flush_i. Full pushes are never accepted, even with a simultaneous pop; there is no combinational r_i→wok_o path.
- FEEDTHROUGH=0:
  - rok_o = !empty && !flush_i; rdata_o = storage[rptr].
  - Minimum latency is 1 cycle from push to rok_o.
- FEEDTHROUGH=1:
  - rok_o = (!empty || w_i) && !flush_i.
  - rdata_o = empty ? wdata_i : storage[rptr].
  - When empty with w_i && r_i: data passes through and nothing is written; pointers and count are unchanged.
  - When empty with w_i && !r_i: normal write.
- Simultaneous push and pop when not empty and not full: both pointers advance, count unchanged.
- Push only: count+1. Pop only: count−1. Count never exceeds DEPTH and never underflows.
- Flush has priority over push and pop:
  - Next cycle: rptr=wptr=count=0, err=0.
  - Push and pop in the flush cycle are ignored and are not flagged as errors.
- err_o:
  - Set on (w_i && !wok_o && !flush_i) or (r_i && !rok_o && !flush_i).
  - Held until flush or reset. The offending transaction is dropped.
- afull_o = (count ≥ AFULL_THRESH), combinational from registered count.
- Reset asserted mid-operation clears state immediately; in-flight data is lost. Behaviour after deassertion is identical to the post-reset state.

Decomposition:
- Shared package hpdcache_pkg gets:
  - a function hpdcache_fifo_cnt_width(DEPTH) = $clog2(DEPTH+1);
  - a localparam giving the refill FIFO depth formula (MSHR_SETS*MSHR_WAYS + margin), so instances size consistently.
- One sub-module: hpdcache_fifo_regbank, a flop-based storage with a single write port and an asynchronous read at rptr. It is separated so a latch- or SRAM-based variant can replace it.

Test Plan:
- DEPTH=3, FT=0:
  - Push A,B,C on consecutive cycles → wok_o=0 after C, count_o=3, afull_o=1 (AFULL_THRESH=3).
  - Pop three times → A,B,C in order, then rok_o=0.
- DEPTH=3, FT=0, full, w_i=1 and r_i=1 in the same cycle → pop of head succeeds, push rejected, err_o=1, count_o=2.
- FT=1, empty, w_i=1, r_i=1, wdata_i=0xDEAD → rok_o=1 and rdata_o=0xDEAD in the same cycle; next cycle count_o=0.
- DEPTH=5 wrap:
  - Sequence of 12 pushes interleaved with pops, occupancy held between 1 and 4 → outputs match a reference queue, pointers wrap 4→0.
  - No err_o.
- FIFO holding 2 entries, err_o=1, flush_i=1 with w_i=1 → next cycle count_o=0, rok_o=0, err_o=0; pushed data absent.
- rst_i asserted asynchronously mid-cycle with count 2 → count_o=0 and rok_o=0 before the next edge; after release, a push then pop of 0x5 returns 0x5.
